action_scheduler: RTL
=====================

Name: action_scheduler

Overview:
- Sits between the raw user/sensor inputs and control_fsm in the Tamaguchi top.
- Synchronizes and debounces the five action sources: alimentar, jugar, curar, dormir (inverted light flag) and caricia (ultrasonic proximity).
- Latches each source's rising edges as sticky pending requests and issues at most one action command at a time, round-robin, over a valid/ready handshake.
- Enforces a cooldown between accepted commands; boton_acelerar shortens the cooldown.

Parameters:
- DEBOUNCE_CYC, 1000000: consecutive stable cycles required before a debounced input changes (20 ms at 50 MHz).
- COOLDOWN_CYC, 25000000: idle cycles after an accepted command (500 ms).
- FAST_DIV, 10: cooldown divisor while fast=1; integer division.

Ports:
- clk  in  1  system clock; the single clock domain.
- rst_neg  in  1  asynchronous, active-low reset.
- req_raw  in  5  raw requests, asynchronous; bit0 alimentar, bit1 jugar, bit2 curar, bit3 dormir, bit4 caricia.
- fast  in  1  accelerate mode; raw, passed through the same 2-flop synchronizer with no debounce.
- cmd_ready  in  1  control_fsm accepts the offered command.
- cmd_valid  out  1  command offered.
- cmd_id  out  3  0 none, 1 alimentar, 2 jugar, 3 curar, 4 dormir, 5 caricia.
- pending  out  5  sticky pending request bits.
- drop_cnt  out  4  saturating count of coalesced (lost duplicate) edges.

Behaviour:
- Reset (rst_neg=0, asynchronous):
  - All outputs clear: cmd_valid=0, cmd_id=0, pending=0, drop_cnt=0.
  - Synchronizers, debounced states and counters clear to 0.
  - Round-robin pointer resets to 4, so bit0 has first priority.
  - FSM goes to IDLE.
  - A reset asserted mid-offer or mid-cooldown aborts immediately, and the pending request is lost.
- Input conditioning, per bit:
  - 2-flop synchronizer, then a debounce counter.
  - The counter resets whenever the synchronized input equals the stable state.
  - When the counter reaches DEBOUNCE_CYC-1 while they differ, the stable state toggles.
  - A stable 0->1 transition produces a one-cycle edge pulse.
- Pending:
  - An edge sets its pending bit on the next clock.
  - An edge on a bit that is already pending is coalesced and increments drop_cnt, saturating at 15.
  - If an edge arrives on the granted bit in the same cycle it is accepted, the bit stays set (re-armed) and drop_cnt does not increment.
- FSM states IDLE -> OFFER -> COOLDOWN -> IDLE:
  - IDLE: if pending!=0, select the first set bit searching upward cyclically from pointer+1. Register cmd_id=index+1 and cmd_valid=1 on the next edge, then enter OFFER. Pending set at cycle N gives cmd_valid high at N+1.
  - OFFER: cmd_valid and cmd_id are held stable until cmd_ready=1. No timeout; cmd_valid is never withdrawn. New edges only accumulate.
  - On acceptance (cmd_valid&cmd_ready): clear the granted pending bit, set pointer=granted index, drop cmd_valid and set cmd_id=0 next cycle.
  - On acceptance, load the cooldown counter with COOLDOWN_CYC, or COOLDOWN_CYC/FAST_DIV if fast=1 that cycle, then enter COOLDOWN.
  - COOLDOWN: decrement the counter each cycle. Leave to IDLE when it reaches 1, so exactly the loaded number of cycles is spent in COOLDOWN. A loaded value of 0 is treated as 1.
  - COOLDOWN: a change of fast mid-cooldown does not reload the counter.
- Widths:
  - Cooldown counter is clog2(COOLDOWN_CYC+1) bits.
  - Debounce counters are clog2(DEBOUNCE_CYC) bits.
  - A pulse shorter than DEBOUNCE_CYC produces no edge.

Decomposition:
- Shared package tamaguchi_pkg holds:
  - CMD_NONE..CMD_CARICIA 3-bit constants.
  - Scheduler state encoding (IDLE=0, OFFER=1, COOLDOWN=2).
  - The req bit index constants.
- Sub-module input_debouncer (sync + debounce + edge pulse, DEBOUNCE_CYC parameter), instantiated 5 times.
- Arbitration, FSM and cooldown stay in action_scheduler.

Test Plan (DEBOUNCE_CYC=4, COOLDOWN_CYC=10, FAST_DIV=2):
- Single request: req_raw[1] held high 10 cycles, cmd_ready tied 1 -> one cmd_valid pulse with cmd_id=2, pending[1] cleared, next offer no earlier than 10 cycles later.
- Glitch rejection: req_raw[0] high for 3 cycles -> no pending, cmd_valid stays 0.
- Simultaneous requests: bits 0, 2 and 4 debounced in the same cycle, ready tied 1 -> cmd_id sequence 1, 3, 5, each separated by 10 cooldown cycles.
- Round-robin: after granting bit 2, bits 1 and 3 both pending -> bit 3 granted first, then bit 1.
- Backpressure and coalescing: cmd_ready=0 for 50 cycles, three separate debounced edges on bit 4 while offering bit0 -> cmd_id=1 held stable, pending[4]=1, drop_cnt=2.
- Fast and reset: fast=1 at acceptance -> cooldown of 5 cycles. Then rst_neg low for 1 cycle mid-OFFER -> immediate cmd_valid=0, pending=0, drop_cnt=0, next grant starts from bit 0.

Source files
------------

// File: rtl/tamaguchi_pkg.sv
// Shared constants for the Tamaguchi control path: command ids, request bit
// positions and the scheduler state encoding.
package tamaguchi_pkg;

  localparam int NUM_REQ = 5;

  localparam int REQ_ALIMENTAR = 0;
  localparam int REQ_JUGAR     = 1;
  localparam int REQ_CURAR     = 2;
  localparam int REQ_DORMIR    = 3;
  localparam int REQ_CARICIA   = 4;

  localparam logic [2:0] CMD_NONE      = 3'd0;
  localparam logic [2:0] CMD_ALIMENTAR = 3'd1;
  localparam logic [2:0] CMD_JUGAR     = 3'd2;
  localparam logic [2:0] CMD_CURAR     = 3'd3;
  localparam logic [2:0] CMD_DORMIR    = 3'd4;
  localparam logic [2:0] CMD_CARICIA   = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_OFFER    = 2'd1,
    S_COOLDOWN = 2'd2
  } sched_state_e;

endpackage

// File: rtl/action_scheduler_if.sv
// Command channel from action_scheduler to control_fsm.
// Handshake: cmd_valid/cmd_id are held stable until cmd_ready; a transfer
// happens on every clock edge where cmd_valid && cmd_ready, and cmd_valid is
// never withdrawn before that transfer.
interface action_scheduler_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_id;

  modport master (output cmd_valid, output cmd_id, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_id, output cmd_ready);
endinterface

// File: rtl/input_debouncer.sv
// One raw asynchronous input: 2-flop synchronizer, stability counter and a
// one-cycle pulse on each debounced 0->1 transition.
module input_debouncer #(
  parameter int DEBOUNCE_CYC = 1000000
) (
  input  logic clk,
  input  logic rst_neg,
  input  logic raw_i,
  output logic edge_o
);

  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic          edge_q, edge_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter only runs while the synchronized input disagrees with the
  // stable state, so any agreeing cycle restarts the qualification window.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    edge_d   = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = ~stable_q;
        edge_d   = ~stable_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_neg) begin
    if (!rst_neg) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      edge_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      edge_q   <= edge_d;
      cnt_q    <= cnt_d;
    end
  end

  assign edge_o = edge_q;

endmodule

// File: rtl/action_scheduler.sv
// Conditions the five action sources, holds sticky pending requests and
// offers one command at a time round-robin, with a cooldown after each grant.
module action_scheduler
  import tamaguchi_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int COOLDOWN_CYC = 25000000,
  parameter int FAST_DIV     = 10
) (
  input  logic                clk,
  input  logic                rst_neg,
  input  logic [NUM_REQ-1:0]  req_raw,
  input  logic                fast,
  action_scheduler_if.master  cmd_if,
  output logic [NUM_REQ-1:0]  pending,
  output logic [3:0]          drop_cnt,
  output sched_state_e        state_dbg
);

  localparam int CW = $clog2(COOLDOWN_CYC + 1);
  localparam logic [CW-1:0] COOL_FULL = CW'(COOLDOWN_CYC);
  localparam logic [CW-1:0] COOL_FAST = CW'(COOLDOWN_CYC / FAST_DIV);

  logic [NUM_REQ-1:0] req_edge, pending_q, pending_d, grant_mask, dup;
  logic [3:0]         drop_q, drop_d;
  logic [4:0]         drop_sum;
  logic               fast_s1_q, fast_s2_q;
  sched_state_e       state_q, state_d;
  logic               cmd_valid_q, cmd_valid_d;
  logic [2:0]         cmd_id_q, cmd_id_d, ptr_q, ptr_d, sel;
  logic               found, accept;
  logic [CW-1:0]      cool_q, cool_d;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_deb
    input_debouncer #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb (
      .clk    (clk),
      .rst_neg(rst_neg),
      .raw_i  (req_raw[g]),
      .edge_o (req_edge[g])
    );
  end

  assign accept = cmd_valid_q & cmd_if.cmd_ready;

  always_comb begin
    grant_mask = '0;
    for (int i = 0; i < NUM_REQ; i++)
      grant_mask[i] = accept && (cmd_id_q == 3'(i + 1));
  end

  // An edge on the bit being granted this cycle re-arms it instead of
  // counting as a lost duplicate.
  assign dup       = req_edge & pending_q & ~grant_mask;
  assign pending_d = (pending_q & ~grant_mask) | req_edge;
  assign drop_sum  = {1'b0, drop_q} + 5'($countones(dup));
  assign drop_d    = (drop_sum > 5'd15) ? 4'hf : drop_sum[3:0];

  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && pending_q[(int'(ptr_q) + k) % NUM_REQ]) begin
        found = 1'b1;
        sel   = 3'((int'(ptr_q) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_valid_d = cmd_valid_q;
    cmd_id_d    = cmd_id_q;
    ptr_d       = ptr_q;
    cool_d      = cool_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          cmd_valid_d = 1'b1;
          cmd_id_d    = sel + 3'd1;
          state_d     = S_OFFER;
        end
      end
      S_OFFER: begin
        if (accept) begin
          cmd_valid_d = 1'b0;
          cmd_id_d    = CMD_NONE;
          ptr_d       = cmd_id_q - 3'd1;
          cool_d      = fast_s2_q ? COOL_FAST : COOL_FULL;
          if (cool_d == '0) cool_d = CW'(1);
          state_d     = S_COOLDOWN;
        end
      end
      S_COOLDOWN: begin
        if (cool_q <= CW'(1)) state_d = S_IDLE;
        else                  cool_d  = cool_q - CW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_neg) begin
    if (!rst_neg) begin
      state_q     <= S_IDLE;
      cmd_valid_q <= 1'b0;
      cmd_id_q    <= CMD_NONE;
      ptr_q       <= 3'd4;
      cool_q      <= '0;
      pending_q   <= '0;
      drop_q      <= '0;
      fast_s1_q   <= 1'b0;
      fast_s2_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_id_q    <= cmd_id_d;
      ptr_q       <= ptr_d;
      cool_q      <= cool_d;
      pending_q   <= pending_d;
      drop_q      <= drop_d;
      fast_s1_q   <= fast;
      fast_s2_q   <= fast_s1_q;
    end
  end

  assign cmd_if.cmd_valid = cmd_valid_q;
  assign cmd_if.cmd_id    = cmd_id_q;
  assign pending          = pending_q;
  assign drop_cnt         = drop_q;
  assign state_dbg        = state_q;

endmodule
